// File: rtl/led_display_hub75_driver_pkg.sv
// Shared types for the LED display pipeline: row-pair layout, HUB75 pin group
// and the driver's sequencing states.
package led_display_hub75_driver_pkg;

    localparam int GL_NUM_COL_PIXELS = 64;
    localparam int GL_RGB_ROW_W      = 6 * GL_NUM_COL_PIXELS;

    typedef struct packed {
        logic [GL_NUM_COL_PIXELS-1:0] red;
        logic [GL_NUM_COL_PIXELS-1:0] green;
        logic [GL_NUM_COL_PIXELS-1:0] blue;
    } rgb_half_t;

    typedef struct packed {
        rgb_half_t top;
        rgb_half_t bot;
    } rgb_row_t;

    // rgb is ordered {r0, g0, b0, r1, g1, b1}
    typedef struct packed {
        logic [5:0] rgb;
        logic       clk;
        logic       latch;
        logic       oe_n;
        logic [3:0] addr;
    } hub75_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_DISPLAY
    } hub75_state_t;

endpackage

// File: rtl/led_display_hub75_driver_clk_tick.sv
// Panel-clock divider: one-cycle tick at every half-phase boundary while enabled.
// Held at zero outside SHIFT so the first low phase starts right after the transfer.
module hub75_clk_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic clear_in,
    input  logic enable_in,
    output logic tick_out
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (reset_in || clear_in || !enable_in)
            cnt <= '0;
        else if (cnt == CW'(CLK_DIV - 1))
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick_out = enable_in && (cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/led_display_hub75_driver.sv
// Shifts one row pair into a HUB75 panel, then blanks, latches and lights it.
// The last latched row stays lit while the next one shifts in.
module led_display_hub75_driver
    import led_display_hub75_driver_pkg::*;
#(
    parameter int CLK_DIV        = 2,
    parameter int LATCH_CYCLES   = 2,
    parameter int DISPLAY_CYCLES = 256
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  rgb_row_t   row_in,
    input  logic       row_valid_in,
    output logic       row_ready_out,
    input  logic [3:0] row_address_in,
    output logic       r0_out,
    output logic       g0_out,
    output logic       b0_out,
    output logic       r1_out,
    output logic       g1_out,
    output logic       b1_out,
    output logic       panel_clk_out,
    output logic       latch_out,
    output logic       oe_n_out,
    output logic [3:0] addr_out
);
    localparam int N       = GL_NUM_COL_PIXELS;
    localparam int PIX_W   = $clog2(N);
    localparam int CYC_MAX = (LATCH_CYCLES > DISPLAY_CYCLES) ? LATCH_CYCLES : DISPLAY_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    hub75_state_t      state;
    logic [5:0][N-1:0] sr;
    logic [PIX_W-1:0]  pix_cnt;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [3:0]        addr_pending;
    logic              phase_high;
    logic              lit;
    logic              tick;
    logic              xfer;
    logic              clk_q;
    logic              latch_q;
    logic              oe_n_q;
    logic [3:0]        addr_q;
    hub75_t            hub;

    assign xfer = row_valid_in && row_ready_out;

    hub75_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .clear_in  (xfer),
        .enable_in (state == ST_SHIFT),
        .tick_out  (tick)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state         <= ST_IDLE;
            sr            <= '0;
            pix_cnt       <= '0;
            cyc_cnt       <= '0;
            addr_pending  <= '0;
            phase_high    <= 1'b0;
            lit           <= 1'b0;
            row_ready_out <= 1'b0;
            clk_q         <= 1'b0;
            latch_q       <= 1'b0;
            oe_n_q        <= 1'b1;
            addr_q        <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    oe_n_q <= !lit;
                    if (xfer) begin
                        sr <= {row_in.top.red, row_in.top.green, row_in.top.blue,
                               row_in.bot.red, row_in.bot.green, row_in.bot.blue};
                        addr_pending  <= row_address_in;
                        pix_cnt       <= PIX_W'(N - 1);
                        phase_high    <= 1'b0;
                        row_ready_out <= 1'b0;
                        state         <= ST_SHIFT;
                    end else begin
                        row_ready_out <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (tick && !phase_high) begin
                        clk_q      <= 1'b1;
                        phase_high <= 1'b1;
                    end else if (tick) begin
                        clk_q      <= 1'b0;
                        phase_high <= 1'b0;
                        if (pix_cnt == '0) begin
                            // new address goes out with the blank so it settles before the latch
                            oe_n_q <= 1'b1;
                            addr_q <= addr_pending;
                            state  <= ST_BLANK;
                        end else begin
                            pix_cnt <= pix_cnt - 1'b1;
                            for (int ch = 0; ch < 6; ch++)
                                sr[ch] <= sr[ch] << 1;
                        end
                    end
                end
                ST_BLANK: begin
                    latch_q <= 1'b1;
                    lit     <= 1'b1;
                    cyc_cnt <= '0;
                    state   <= ST_LATCH;
                end
                ST_LATCH: begin
                    if (cyc_cnt == CYC_W'(LATCH_CYCLES - 1)) begin
                        latch_q <= 1'b0;
                        oe_n_q  <= 1'b0;
                        cyc_cnt <= '0;
                        state   <= ST_DISPLAY;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                ST_DISPLAY: begin
                    if (cyc_cnt == CYC_W'(DISPLAY_CYCLES - 1)) begin
                        oe_n_q        <= !lit;
                        row_ready_out <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Data pins are the shift-register MSBs, so they hold their last value outside SHIFT.
    always_comb begin
        hub = '0;
        for (int ch = 0; ch < 6; ch++)
            hub.rgb[ch] = sr[ch][N-1];
        hub.clk   = clk_q;
        hub.latch = latch_q;
        hub.oe_n  = oe_n_q;
        hub.addr  = addr_q;
    end

    assign {r0_out, g0_out, b0_out, r1_out, g1_out, b1_out} = hub.rgb;
    assign panel_clk_out = hub.clk;
    assign latch_out     = hub.latch;
    assign oe_n_out      = hub.oe_n;
    assign addr_out      = hub.addr;

endmodule

// File: tb/tb_led_display_hub75_driver.sv
// Bench for led_display_hub75_driver: every cycle of each row is compared against
// a timeline model derived from the row-period arithmetic.
module tb_led_display_hub75_driver;
    import led_display_hub75_driver_pkg::*;

    localparam int N  = GL_NUM_COL_PIXELS;
    localparam int LC = 2;

    typedef struct packed {
        logic [5:0] rgb;
        logic       clk;
        logic       latch;
        logic       oe_n;
        logic [3:0] addr;
        logic       ready;
    } obs_t;

    typedef struct {
        int           w;
        logic [N-1:0] top_red;
        logic [N-1:0] bot_blue;
        logic [3:0]   addr;
        int           exp_rises;
        int           exp_period;
    } vec_t;

    logic clk_in = 1'b0;
    logic reset_in;

    rgb_row_t   row_a, row_b;
    logic       vld_a, vld_b, rdy_a, rdy_b;
    logic [3:0] ra_a, ra_b, adr_a, adr_b;
    logic       r0_a, g0_a, b0_a, r1_a, g1_a, b1_a, pclk_a, lat_a, oe_a;
    logic       r0_b, g0_b, b0_b, r1_b, g1_b, b1_b, pclk_b, lat_b, oe_b;

    int         checks = 0;
    int         errors = 0;
    int         cdiv[2] = '{2, 1};
    int         dcyc[2] = '{256, 1};
    logic       lit_m[2];
    logic [3:0] addr_m[2];
    logic [5:0] rgb_m[2];

    always #5 clk_in = ~clk_in;

    led_display_hub75_driver u_a (
        .clk_in(clk_in), .reset_in(reset_in), .row_in(row_a), .row_valid_in(vld_a),
        .row_ready_out(rdy_a), .row_address_in(ra_a),
        .r0_out(r0_a), .g0_out(g0_a), .b0_out(b0_a), .r1_out(r1_a), .g1_out(g1_a), .b1_out(b1_a),
        .panel_clk_out(pclk_a), .latch_out(lat_a), .oe_n_out(oe_a), .addr_out(adr_a)
    );

    led_display_hub75_driver #(.CLK_DIV(1), .LATCH_CYCLES(LC), .DISPLAY_CYCLES(1)) u_b (
        .clk_in(clk_in), .reset_in(reset_in), .row_in(row_b), .row_valid_in(vld_b),
        .row_ready_out(rdy_b), .row_address_in(ra_b),
        .r0_out(r0_b), .g0_out(g0_b), .b0_out(b0_b), .r1_out(r1_b), .g1_out(g1_b), .b1_out(b1_b),
        .panel_clk_out(pclk_b), .latch_out(lat_b), .oe_n_out(oe_b), .addr_out(adr_b)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic obs_t sample(input int w);
        obs_t o;
        if (w == 0) o = {{r0_a, g0_a, b0_a, r1_a, g1_a, b1_a}, pclk_a, lat_a, oe_a, adr_a, rdy_a};
        else        o = {{r0_b, g0_b, b0_b, r1_b, g1_b, b1_b}, pclk_b, lat_b, oe_b, adr_b, rdy_b};
        return o;
    endfunction

    function automatic logic [5:0] pix(input rgb_row_t r, input int i);
        return {r.top.red[i], r.top.green[i], r.top.blue[i], r.bot.red[i], r.bot.green[i], r.bot.blue[i]};
    endfunction

    function automatic rgb_row_t rand_row();
        rgb_row_t r;
        r.top.red   = {$urandom(), $urandom()};
        r.top.green = {$urandom(), $urandom()};
        r.top.blue  = {$urandom(), $urandom()};
        r.bot.red   = {$urandom(), $urandom()};
        r.bot.green = {$urandom(), $urandom()};
        r.bot.blue  = {$urandom(), $urandom()};
        return r;
    endfunction

    // Expected pins at cycle t after the transfer edge, from the row-period breakdown.
    function automatic obs_t model(input int t, input int c, input int d, input rgb_row_t r,
                                   input logic [3:0] an, input logic [3:0] ao, input logic lit);
        obs_t o;
        int   s;
        s = N * 2 * c;
        o = '{rgb: pix(r, 0), clk: 1'b0, latch: 1'b0, oe_n: 1'b1, addr: an, ready: 1'b0};
        if (t <= s) begin
            o.rgb  = pix(r, N - 1 - (t - 1) / (2 * c));
            o.clk  = ((t - 1) % (2 * c)) >= c;
            o.oe_n = !lit;
            o.addr = ao;
        end else if (t == s + 1) begin
            o.oe_n = 1'b1;
        end else if (t <= s + 1 + LC) begin
            o.latch = 1'b1;
        end else if (t <= s + 1 + LC + d) begin
            o.oe_n = 1'b0;
        end else begin
            o.oe_n  = 1'b0;
            o.ready = 1'b1;
        end
        return o;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_obs(input string name, input int t, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%b exp=%b (rgb,clk,latch,oe_n,addr,ready)", name, t, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic set_in(input int w, input logic v, input rgb_row_t r, input logic [3:0] adr);
        if (w == 0) begin vld_a = v; row_a = r; ra_a = adr; end
        else        begin vld_b = v; row_b = r; ra_b = adr; end
    endtask

    task automatic wait_ready(input int w, input string name);
        int   n;
        obs_t o;
        n = 0;
        o = sample(w);
        while (!o.ready && n < 2000) begin
            step();
            n++;
            o = sample(w);
        end
        check_int({name, "_ready_wait"}, int'(o.ready), 1);
    endtask

    task automatic reset_models();
        for (int i = 0; i < 2; i++) begin
            lit_m[i]  = 1'b0;
            addr_m[i] = 4'd0;
            rgb_m[i]  = 6'd0;
        end
    endtask

    // Drives one transfer and compares every cycle up to the next ready (or abort_t).
    task automatic run_row(input int w, input rgb_row_t r, input logic [3:0] adr, input bit hold,
                           input int glitch_t, input int abort_t, input string name);
        int   s, p, rises, period, oe_hi;
        logic prev_clk;
        obs_t o, e;
        s = N * 2 * cdiv[w];
        p = 1 + s + 1 + LC + dcyc[w];
        wait_ready(w, name);
        set_in(w, 1'b1, r, adr);
        step();
        if (!hold) set_in(w, 1'b0, r, adr);
        rises = 0; period = 0; oe_hi = 0; prev_clk = 1'b0;
        for (int t = 1; t <= p; t++) begin
            o = sample(w);
            e = model(t, cdiv[w], dcyc[w], r, adr, addr_m[w], lit_m[w]);
            check_obs(name, t, o, e);
            if (o.clk && !prev_clk) rises++;
            prev_clk = o.clk;
            if (o.oe_n) oe_hi++;
            if (o.ready && period == 0) period = t;
            if (t == abort_t) return;
            if (t == glitch_t) set_in(w, 1'b1, rand_row(), ~adr);
            else if (t == glitch_t + 1) set_in(w, 1'b0, r, adr);
            if (t < p) step();
        end
        check_int({name, "_rises"}, rises, N);
        check_int({name, "_period"}, period, p);
        check_int({name, "_oe_high"}, oe_hi, lit_m[w] ? 1 + LC : s + 1 + LC);
        lit_m[w]  = 1'b1;
        addr_m[w] = adr;
        rgb_m[w]  = pix(r, 0);
    endtask

    initial begin
        vec_t       vecs[4];
        rgb_row_t   r;
        obs_t       rst_exp, idle_exp;
        int         gap;
        logic [3:0] adr;

        vecs[0] = '{w: 0, top_red: {32{2'b10}}, bot_blue: '1, addr: 4'd5,  exp_rises: 64, exp_period: 516};
        vecs[1] = '{w: 0, top_red: '0,          bot_blue: '0, addr: 4'd15, exp_rises: 64, exp_period: 516};
        vecs[2] = '{w: 1, top_red: '1,          bot_blue: {32{2'b01}}, addr: 4'd0, exp_rises: 64, exp_period: 133};
        vecs[3] = '{w: 1, top_red: {16{4'hC}},  bot_blue: {8{8'h0F}},  addr: 4'd9, exp_rises: 64, exp_period: 133};

        rst_exp = '{rgb: 6'd0, clk: 1'b0, latch: 1'b0, oe_n: 1'b1, addr: 4'd0, ready: 1'b0};
        reset_in = 1'b1;
        set_in(0, 1'b0, '0, 4'd0);
        set_in(1, 1'b0, '0, 4'd0);
        reset_models();

        // Reset held five cycles, then ready one cycle after release.
        for (int i = 0; i < 5; i++) begin
            step();
            check_obs("reset_a", i, sample(0), rst_exp);
            check_obs("reset_b", i, sample(1), rst_exp);
        end
        reset_in = 1'b0;
        step();
        rst_exp.ready = 1'b1;
        check_obs("release_a", 0, sample(0), rst_exp);
        check_obs("release_b", 0, sample(1), rst_exp);

        // Table vectors: other channels random, checked channels fixed.
        for (int i = 0; i < 4; i++) begin
            r = rand_row();
            r.top.red  = vecs[i].top_red;
            r.bot.blue = vecs[i].bot_blue;
            run_row(vecs[i].w, r, vecs[i].addr, 1'b0, 0, 0, $sformatf("vec%0d", i));
            check_int($sformatf("vec%0d_r0_first", i), int'(r0_a & (vecs[i].w == 0)) + int'(r0_b & (vecs[i].w == 1)),
                      int'(vecs[i].top_red[0]));
        end

        // New data offered mid-shift must be ignored.
        run_row(0, rand_row(), 4'd3, 1'b0, 50, 0, "busy_valid");

        // Back-to-back with valid held; address walks 0..15 and wraps to 0.
        for (int i = 0; i <= 16; i++)
            run_row(0, rand_row(), 4'(i % 16), 1'b1, 0, 0, $sformatf("b2b%0d", i));
        set_in(0, 1'b0, '0, 4'd0);

        // Reset at the start of pixel 30, then a clean full row.
        run_row(0, rand_row(), 4'd7, 1'b0, 0, 30 * 4 + 1, "mid_shift");
        reset_in = 1'b1;
        step();
        rst_exp.ready = 1'b0;
        check_obs("mid_reset_a", 0, sample(0), rst_exp);
        check_obs("mid_reset_b", 0, sample(1), rst_exp);
        reset_in = 1'b0;
        reset_models();
        step();
        rst_exp.ready = 1'b1;
        check_obs("mid_release_a", 0, sample(0), rst_exp);
        run_row(0, rand_row(), 4'd12, 1'b0, 0, 0, "after_reset");

        // Random rows on the fast instance with random idle gaps.
        for (int i = 0; i < 6; i++) begin
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                idle_exp = '{rgb: rgb_m[1], clk: 1'b0, latch: 1'b0, oe_n: !lit_m[1], addr: addr_m[1], ready: 1'b1};
                check_obs($sformatf("idle%0d", i), g, sample(1), idle_exp);
                step();
            end
            adr = 4'($urandom_range(0, 15));
            run_row(1, rand_row(), adr, 1'b0, (i % 2 == 0) ? 7 : 0, 0, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
